z80_isr_tracker: RTL
====================

Z80_ISR_TRACKER -- requirements
Module: z80_isr_tracker

Interface
REQ-001 HIST_DEPTH, 8, depth of the completed-instruction history buffer; power of 2, range 2..16.
REQ-002 HW, $clog2(HIST_DEPTH), width of hist_idx; derived, not overridable.
REQ-003 clk  in  1  Z80 system clock; all state changes on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 m1_n  in  1  Z80 M1, active low.
REQ-006 iorq_n  in  1  Z80 IORQ, active low.
REQ-007 rd_n  in  1  Z80 RD, active low.
REQ-008 data  in  8  Z80 data bus.
REQ-009 new_isr  out  1  next M1 begins a new instruction.
REQ-010 isr_done  out  1  one-clk pulse when an instruction's final opcode byte is committed.
REQ-011 prefix  out  2  class of last committed instruction: 00 none, 01 CB, 10 ED, 11 DD/FD.
REQ-012 xy_sel  out  1  0 = IX (DD), 1 = IY (FD); valid when prefix = 11.
REQ-013 jmp_class  out  3  control-flow class of last committed instruction (REQ-024).
REQ-014 last_isr_jmp  out  1  high when jmp_class = 1 (unconditional JP nn).
REQ-015 io_valid  out  1  last committed instruction is an I/O instruction.
REQ-016 io_direction  out  1  0 = OUT, 1 = IN.
REQ-017 int_ack  out  1  one-clk pulse on interrupt-acknowledge M1.
REQ-018 hist_idx  in  HW  history read index; 0 = most recent.
REQ-019 hist_data  out  11  {prefix[1:0], xy_sel, opcode[7:0]} of the selected entry; combinational read.
REQ-020 hist_count  out  HW+1  valid history entries, saturating at HIST_DEPTH.

Function
REQ-021 Capture: each clk with m1_n=0, rd_n=0 and iorq_n=1 shall latch data into an opcode register; the last such sample before m1_n rises is the fetched byte.
REQ-022 Commit: a clk edge sampling m1_n=1 after a previous sample of m1_n=0 shall process the latched byte; outputs update on that edge (1-clk latency from M1 deassertion).
REQ-023 FSM states: OP (expect opcode), CB, ED, XY. Transitions on commit:
 - OP: CB->CB; ED->ED; DD/FD->XY with xy_sel set; any other byte -> done, prefix=00.
 - CB, ED: any byte -> done, prefix=01/10 respectively.
 - XY: DD/FD -> XY, xy_sel updated (last prefix wins); ED -> ED (index prefix discarded); CB -> done, prefix=11 (displacement and opcode of DDCB/FDCB are non-M1 reads and are not tracked); other -> done, prefix=11.
 - done = next state OP, new_isr=1, isr_done pulse, history push; non-done commits drive new_isr=0.
REQ-024 jmp_class on done, unprefixed byte: C3->1; 11ccc010->2; 18, 10, 20/28/30/38->3; CD or 11ccc100->4; C9 or 11ccc000->5; 11nnn111->6; E9->7 (also when prefix=11); ED 45/4D->5; all else 0.
REQ-025 io_valid/io_direction on done: unprefixed D3 -> 1/0; DB -> 1/1; ED 01rrr000 -> 1/1; ED 01rrr001 -> 1/0; ED 101xx010 -> 1/1; ED 101xx011 -> 1/0; all else io_valid=0, io_direction unchanged.
REQ-026 Interrupt acknowledge: a sample with m1_n=0 and iorq_n=0 shall pulse int_ack once per M1, force state OP, set new_isr=1, suppress the following commit, and push no history.
REQ-027 jmp_class, prefix, xy_sel, io_* shall hold between done events; isr_done and int_ack are single-clk pulses.
REQ-028 History is circular; a push at full overwrites the oldest; hist_idx >= hist_count returns 0.

Reset
REQ-029 reset_n=0 shall immediately force state OP, new_isr=1, isr_done=0, prefix=00, xy_sel=0, jmp_class=0, last_isr_jmp=0, io_valid=0, io_direction=0, int_ack=0, hist_count=0, opcode register=00.
REQ-030 Reset mid-prefix (e.g. after DD) shall discard the prefix; the next M1 after release is treated as a new instruction.

Configuration
REQ-031 Macro Z80_ISR_TRACKER_HIST_EN: defined -> history buffer, hist_data and hist_count per REQ-019/020/028.
REQ-032 Undefined -> no history storage is synthesised; hist_data=0 and hist_count=0 constant; all other behaviour identical.

Verification
REQ-033 M1 fetch C3 -> jmp_class=1, last_isr_jmp=1, prefix=00, isr_done one pulse, hist_data[idx0]=0x0C3.
REQ-034 DD, FD, 21 -> new_isr 0,0,1; prefix=11, xy_sel=1, one isr_done, hist_count=1.
REQ-035 ED, B3 (OTIR) -> io_valid=1, io_direction=0, prefix=10; then DB -> io_direction=1, prefix=00.
REQ-036 DD then int-ack M1 (m1_n=0, iorq_n=0, data FF) -> int_ack one pulse, new_isr=1, no isr_done; next 00 commits prefix=00.
REQ-037 Push HIST_DEPTH+3 distinct opcodes -> hist_count=HIST_DEPTH, idx0 = last, idx HIST_DEPTH-1 = 4th pushed; with macro undefined hist_data=0.
REQ-038 Assert reset_n low after FD -> all outputs at REQ-029 values asynchronously; after release, 3E commits prefix=00.

Source files
------------

// File: rtl/z80_isr_tracker_if.sv
// ---------------------------------------------------------------------------
// z80_isr_tracker_if
// Z80 CPU bus signals as seen by the instruction tracker.
//   m1_n   : Z80 M1 (opcode fetch / interrupt acknowledge), active low
//   iorq_n : Z80 IORQ, active low
//   rd_n   : Z80 RD, active low
//   data   : 8-bit Z80 data bus
// Modports:
//   master : the side that drives the bus (CPU model, bench)
//   slave  : passive observer (the tracker)
// ---------------------------------------------------------------------------
interface z80_isr_tracker_if;
    logic       m1_n;
    logic       iorq_n;
    logic       rd_n;
    logic [7:0] data;

    modport master (output m1_n, iorq_n, rd_n, data);
    modport slave  (input  m1_n, iorq_n, rd_n, data);
endinterface

// File: rtl/z80_isr_tracker.sv
// ---------------------------------------------------------------------------
// z80_isr_tracker
// Watches Z80 M1 cycles, decodes prefix sequences (CB / ED / DD / FD) and
// reports, for every completed instruction, its prefix class, control-flow
// class and I/O class. Interrupt-acknowledge M1 cycles are flagged and
// otherwise ignored.
//
// Optional feature (macro Z80_ISR_TRACKER_HIST_EN): circular history of the
// last HIST_DEPTH completed instructions, readable combinationally. Without
// the macro no storage is built and hist_data / hist_count read as 0.
//
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   bus           : Z80 bus (slave modport of z80_isr_tracker_if)
//   new_isr       : next M1 begins a new instruction
//   isr_done      : 1-clk pulse when an instruction completes
//   prefix        : 00 none, 01 CB, 10 ED, 11 DD/FD
//   xy_sel        : 0 = IX, 1 = IY (meaningful when prefix = 11)
//   jmp_class     : control-flow class of last completed instruction
//   last_isr_jmp  : jmp_class == 1 (unconditional JP nn)
//   io_valid      : last completed instruction was IN/OUT
//   io_direction  : 0 = OUT, 1 = IN (holds when io_valid drops)
//   int_ack       : 1-clk pulse on interrupt-acknowledge M1
//   hist_idx      : history read index, 0 = most recent
//   hist_data     : {prefix, xy_sel, opcode} of selected entry
//   hist_count    : valid history entries, saturating at HIST_DEPTH
// ---------------------------------------------------------------------------
module z80_isr_tracker #(
    parameter int  HIST_DEPTH = 8,
    localparam int HW         = $clog2(HIST_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    z80_isr_tracker_if.slave        bus,
    output logic                    new_isr,
    output logic                    isr_done,
    output logic [1:0]              prefix,
    output logic                    xy_sel,
    output logic [2:0]              jmp_class,
    output logic                    last_isr_jmp,
    output logic                    io_valid,
    output logic                    io_direction,
    output logic                    int_ack,
    input  logic [HW-1:0]           hist_idx,
    output logic [10:0]             hist_data,
    output logic [HW:0]             hist_count
);

    typedef enum logic [1:0] {ST_OP, ST_CB, ST_ED, ST_XY} state_t;

    state_t     state, state_next;
    logic [7:0] opcode;
    logic       m1_low_q;     // previous sample had m1_n = 0
    logic       iack_q;       // current M1 is an interrupt acknowledge
    logic       commit, iack_start, is_idx_byte, is_pfx;
    logic       done, done_io_valid, done_io_dir;
    logic [1:0] done_prefix;
    logic [2:0] done_jmp;

    // Rising edge of m1_n, except after an interrupt acknowledge M1.
    assign commit      = bus.m1_n && m1_low_q && !iack_q;
    assign iack_start  = !bus.m1_n && !bus.iorq_n && !iack_q;
    assign is_idx_byte = (opcode == 8'hDD) || (opcode == 8'hFD);

    // Control-flow class of an unprefixed opcode.
    function automatic logic [2:0] op_jmp_class(input logic [7:0] op);
        if (op == 8'hC3)                                         return 3'd1;
        if (op[7:6] == 2'b11 && op[2:0] == 3'b010)               return 3'd2;
        if (op == 8'h18 || op == 8'h10 ||
            (op[7:5] == 3'b001 && op[2:0] == 3'b000))            return 3'd3;
        if (op == 8'hCD || (op[7:6] == 2'b11 && op[2:0] == 3'b100)) return 3'd4;
        if (op == 8'hC9 || (op[7:6] == 2'b11 && op[2:0] == 3'b000)) return 3'd5;
        if (op[7:6] == 2'b11 && op[2:0] == 3'b111)               return 3'd6;
        if (op == 8'hE9)                                         return 3'd7;
        return 3'd0;
    endfunction

    // Bus sampling: opcode capture, M1 edge detect, int-ack tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode   <= 8'h00;
            m1_low_q <= 1'b0;
            iack_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values of its peers.
            m1_low_q <= !bus.m1_n;
            if (!bus.m1_n && !bus.rd_n && bus.iorq_n)
                opcode <= bus.data;
            if (bus.m1_n)
                iack_q <= 1'b0;
            else if (!bus.iorq_n)
                iack_q <= 1'b1;
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_OP;
        else          state <= state_next;
    end

    // FSM: next state. is_pfx marks a commit that does not finish the instruction.
    always_comb begin
        // NOTE: defaults first so no path leaves a value unassigned (no latches).
        state_next = state;
        is_pfx     = 1'b0;
        if (iack_start) begin
            state_next = ST_OP;
        end else if (commit) begin
            unique case (state)
                ST_OP:   is_pfx = is_idx_byte || opcode == 8'hCB || opcode == 8'hED;
                ST_XY:   is_pfx = is_idx_byte || opcode == 8'hED;  // CB after DD/FD completes
                default: is_pfx = 1'b0;
            endcase
            if (!is_pfx)               state_next = ST_OP;
            else if (opcode == 8'hCB)  state_next = ST_CB;
            else if (opcode == 8'hED)  state_next = ST_ED;  // ED drops a pending index prefix
            else                       state_next = ST_XY;
        end
    end

    // FSM: decode of what a completing commit reports.
    always_comb begin
        done          = commit && !is_pfx;
        done_prefix   = 2'b00;
        done_jmp      = 3'd0;
        done_io_valid = 1'b0;
        done_io_dir   = 1'b0;
        unique case (state)
            ST_OP: begin
                done_jmp = op_jmp_class(opcode);
                if (opcode == 8'hD3 || opcode == 8'hDB) begin
                    done_io_valid = 1'b1;
                    done_io_dir   = opcode[3];
                end
            end
            ST_CB: done_prefix = 2'b01;
            ST_ED: begin
                done_prefix = 2'b10;
                if (opcode == 8'h45 || opcode == 8'h4D) done_jmp = 3'd5;  // RETN / RETI
                // IN r,(C) / OUT (C),r and the block I/O group; bit 0 clear means IN.
                if ((opcode[7:6] == 2'b01  && opcode[2:1] == 2'b00) ||
                    (opcode[7:5] == 3'b101 && opcode[2:1] == 2'b01)) begin
                    done_io_valid = 1'b1;
                    done_io_dir   = !opcode[0];
                end
            end
            ST_XY: begin
                done_prefix = 2'b11;
                if (opcode == 8'hE9) done_jmp = 3'd7;  // JP (IX) / JP (IY)
            end
            default: ;
        endcase
    end

    // Registered outputs: hold between completions, pulses last one clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            new_isr      <= 1'b1;
            isr_done     <= 1'b0;
            int_ack      <= 1'b0;
            prefix       <= 2'b00;
            xy_sel       <= 1'b0;
            jmp_class    <= 3'd0;
            io_valid     <= 1'b0;
            io_direction <= 1'b0;
        end else begin
            isr_done <= done;
            int_ack  <= iack_start;
            if (iack_start)  new_isr <= 1'b1;
            else if (commit) new_isr <= done;
            if (commit && is_idx_byte && (state == ST_OP || state == ST_XY))
                xy_sel <= (opcode == 8'hFD);
            if (done) begin
                prefix    <= done_prefix;
                jmp_class <= done_jmp;
                io_valid  <= done_io_valid;
                if (done_io_valid) io_direction <= done_io_dir;
            end
        end
    end

    assign last_isr_jmp = (jmp_class == 3'd1);

`ifdef Z80_ISR_TRACKER_HIST_EN
    logic [10:0]   hist_mem [HIST_DEPTH];
    logic [HW-1:0] wr_ptr, rd_ptr;
    logic [10:0]   push_entry;

    // The IX/IY bit is only meaningful for index-prefixed entries.
    assign push_entry = {done_prefix, (done_prefix == 2'b11) ? xy_sel : 1'b0, opcode};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            hist_count <= '0;
        end else if (done) begin
            wr_ptr <= wr_ptr + HW'(1);  // power-of-2 depth: wraps naturally
            if (hist_count != (HW+1)'(HIST_DEPTH))
                hist_count <= hist_count + (HW+1)'(1);
        end
    end

    // NOTE: storage is not reset; entries at or beyond hist_count are masked on read.
    always_ff @(posedge clk) begin
        if (done) hist_mem[wr_ptr] <= push_entry;
    end

    assign rd_ptr    = wr_ptr - HW'(1) - hist_idx;
    assign hist_data = ({1'b0, hist_idx} < hist_count) ? hist_mem[rd_ptr] : 11'h000;
`else
    logic unused_hist_idx;
    assign unused_hist_idx = ^hist_idx;
    assign hist_data       = 11'h000;
    assign hist_count      = '0;
`endif

endmodule
